multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_W, default 3: width of alu_op_o; values below SHALL be zero-extended; legal range 3..8.
REQ-002 Parameter USE_MEM_READY, default 1: 1 = memory states wait on mem_ready_i; 0 = mem_ready_i ignored, memory treated as single-cycle.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 opcode_i  in  6  instruction opcode field from the instruction register.
REQ-006 zero_i  in  1  ALU zero flag.
REQ-007 mem_ready_i  in  1  memory access completes this cycle.
REQ-008 pc_write_o  out  1  PC load enable.
REQ-009 iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_read_o / mem_write_o  out  1 each  memory strobes.
REQ-011 ir_write_o  out  1  instruction register load enable.
REQ-012 reg_dst_o  out  1  write register: 1 = rd, 0 = rt.
REQ-013 mem_to_reg_o  out  1  write-back data: 1 = MDR, 0 = ALUOut.
REQ-014 reg_write_o  out  1  register file write enable.
REQ-015 alu_src_a_o  out  1  0 = PC, 1 = rs.
REQ-016 alu_src_b_o  out  2  00 = rt, 01 = const 4, 10 = sign/zero-ext immediate, 11 = immediate<<2.
REQ-017 pc_src_o  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
REQ-018 alu_op_o  out  ALU_OP_W  ALU operation code.
REQ-019 state_o  out  4  current state encoding, for debug.
REQ-020 illegal_o  out  1  high while in TRAP.

Function
REQ-021 The block SHALL be a Moore FSM; pc_write_o and ir_write_o in FETCH, and the state exit from memory states, are additionally gated by mem_ready_i (forced true when USE_MEM_READY=0).
REQ-022 Any output not listed for a state SHALL be 0.
REQ-023 alu_op_o codes SHALL be: 000 LUI, 001 OR, 010 AND, 011 SUB, 100 ADD, 111 R-type (funct-decoded).
REQ-024 Supported opcodes SHALL be: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
REQ-025 States/encodings SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, TRAP 15; unused encodings SHALL go to TRAP.
REQ-026 FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=ADD; ir_write=pc_write=mem_ready; hold until mem_ready, then DECODE.
REQ-027 DECODE: src_a=0, src_b=11, alu_op=ADD; opcode_i SHALL be latched into an internal register used by all later states; next: LW/SW->MEM_ADDR, R->R_EXEC, ADDI/ANDI/ORI/LUI->I_EXEC, BEQ/BNE->BRANCH, J->JUMP, other->TRAP.
REQ-028 MEM_ADDR: src_a=1, src_b=10, alu_op=ADD; LW->MEM_RD, SW->MEM_WR.
REQ-029 MEM_RD: mem_read=1, iord=1; hold until mem_ready, then MEM_WB.
REQ-030 MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; ->FETCH.
REQ-031 MEM_WR: mem_write=1, iord=1; hold until mem_ready, then FETCH.
REQ-032 R_EXEC: src_a=1, src_b=00, alu_op=111; ->R_WB. R_WB: reg_dst=1, reg_write=1; ->FETCH.
REQ-033 I_EXEC: src_a=1, src_b=10, alu_op per REQ-023 from latched opcode; ->I_WB. I_WB: reg_dst=0, reg_write=1; ->FETCH.
REQ-034 BRANCH: src_a=1, src_b=00, alu_op=SUB, pc_src=01; pc_write = (BEQ & zero_i) | (BNE & ~zero_i); ->FETCH.
REQ-035 JUMP: pc_src=10, pc_write=1; ->FETCH.
REQ-036 TRAP: illegal_o=1, all enables 0; SHALL remain until reset.
REQ-037 opcode_i changes outside DECODE SHALL have no effect.

Reset
REQ-038 reset_i=1 SHALL immediately force state FETCH, latched opcode 0x00, and all outputs (including combinational ones) to 0, independent of clk_i.
REQ-039 Reset asserted mid-instruction (including during a memory wait) SHALL abort it with no further write enable; the first cycle after release SHALL be FETCH with mem_read=1.

Verification
REQ-040 R-type, mem_ready=1: state_o 0,1,6,7,0; reg_write=1 and reg_dst=1 only in cycle 4.
REQ-041 LW, mem_ready low 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0; mem_to_reg=reg_write=1 only in state 4.
REQ-042 BEQ zero_i=1 -> pc_write=1, pc_src=01 in state 10; BNE zero_i=1 -> pc_write=0.
REQ-043 Opcode 0x3F -> state 15, illegal_o=1 held 10 cycles; reset -> state 0, illegal_o=0.
REQ-044 Reset pulsed asynchronously in MEM_WR -> all outputs 0 before next edge; no mem_write after release.
REQ-045 USE_MEM_READY=0, mem_ready_i=0, ALU_OP_W=5: ORI completes in 4 cycles with alu_op_o=00001 in I_EXEC.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Control unit for a classic multicycle MIPS-style datapath. It is a Moore
//   FSM that walks each instruction through FETCH, DECODE and a short
//   class-specific tail. The opcode is captured once in DECODE, so the tail
//   states never depend on the live instruction bus.
//
// Parameters
//   ALU_OP_W       width of alu_op_o (3..8); the 3-bit code is zero-extended
//   USE_MEM_READY  1: memory states wait on mem_ready_i; 0: memory is single-cycle
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   opcode_i                opcode field from the instruction register
//   zero_i                  ALU zero flag (used by BEQ/BNE)
//   mem_ready_i             memory access completes this cycle
//   pc_write_o, iord_o      PC load enable, address select (0 PC / 1 ALUOut)
//   mem_read_o, mem_write_o memory strobes
//   ir_write_o              instruction register load enable
//   reg_dst_o, mem_to_reg_o write register select (1 rd), write-back select (1 MDR)
//   reg_write_o             register file write enable
//   alu_src_a_o/_b_o        ALU operand selects
//   pc_src_o                next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   alu_op_o                ALU operation code
//   state_o                 current state, for debug
//   illegal_o               high while trapped on an unsupported opcode
module multicycle_control #(
  parameter int ALU_OP_W      = 3,
  parameter int USE_MEM_READY = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [5:0]          opcode_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          pc_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [3:0]          state_o,
  output logic                illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_LUI   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  state_t     state;
  logic [5:0] op_latched;
  logic       ready;
  logic [2:0] alu_code;

  // ALU operation for the immediate-class instructions.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  // With handshaking disabled every memory access finishes in one cycle.
  assign ready = (USE_MEM_READY != 0) ? mem_ready_i : 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= S_FETCH;
      op_latched <= 6'h00;
    end else begin
      case (state)
        S_FETCH:  if (ready) state <= S_DECODE;
        S_DECODE: begin
          op_latched <= opcode_i;
          case (opcode_i)
            OP_LW, OP_SW:                      state <= S_MEM_ADDR;
            OP_R:                              state <= S_R_EXEC;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state <= S_I_EXEC;
            OP_BEQ, OP_BNE:                    state <= S_BRANCH;
            OP_J:                              state <= S_JUMP;
            default:                           state <= S_TRAP;
          endcase
        end
        S_MEM_ADDR: begin
          if (op_latched == OP_LW)      state <= S_MEM_RD;
          else if (op_latched == OP_SW) state <= S_MEM_WR;
          else                          state <= S_TRAP;
        end
        S_MEM_RD: if (ready) state <= S_MEM_WB;
        S_MEM_WB: state <= S_FETCH;
        S_MEM_WR: if (ready) state <= S_FETCH;
        S_R_EXEC: state <= S_R_WB;
        S_R_WB:   state <= S_FETCH;
        S_I_EXEC: state <= S_I_WB;
        S_I_WB:   state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_TRAP;
      endcase
    end
  end

  // Output decode. Reset masks everything so that outputs drop to zero the
  // moment reset_i rises, even the terms that follow live inputs.
  always_comb begin
    pc_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    pc_src_o     = 2'b00;
    alu_code     = ALU_LUI;
    illegal_o    = 1'b0;
    if (!reset_i) begin
      case (state)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          alu_code    = ALU_ADD;
          ir_write_o  = ready;
          pc_write_o  = ready;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          alu_code    = ALU_ADD;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_code    = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEM_WB: begin
          mem_to_reg_o = 1'b1;
          reg_write_o  = 1'b1;
        end
        S_MEM_WR: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_code    = ALU_RTYPE;
        end
        S_R_WB: begin
          reg_dst_o   = 1'b1;
          reg_write_o = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_code    = imm_alu_op(op_latched);
        end
        S_I_WB:   reg_write_o = 1'b1;
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_code    = ALU_SUB;
          pc_src_o    = 2'b01;
          pc_write_o  = ((op_latched == OP_BEQ) &&  zero_i) ||
                        ((op_latched == OP_BNE) && !zero_i);
        end
        S_JUMP: begin
          pc_src_o   = 2'b10;
          pc_write_o = 1'b1;
        end
        S_TRAP:   illegal_o = 1'b1;
        default:  illegal_o = 1'b0;
      endcase
    end
  end

  assign alu_op_o = ALU_OP_W'(alu_code);
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Two instances: dut_a with default parameters (memory handshake honoured,
//   3-bit ALU op) and dut_b with USE_MEM_READY=0, ALU_OP_W=5. The stimulus
//   process works at instruction level: for each instruction it lays out the
//   cycle-by-cycle expected outputs and queues them; a monitor process pops
//   and compares on every falling edge (or on demand mid-cycle).
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic       reset_a, zero_a, ready_a;
  logic [5:0] op_a;
  logic       pcw_a, iord_a, mrd_a, mwr_a, irw_a, rdst_a, m2r_a, rw_a, sa_a, ill_a;
  logic [1:0] sb_a, ps_a;
  logic [2:0] aop_a;
  logic [3:0] st_a;

  // dut_b signals
  logic       reset_b, zero_b;
  logic       ready_b = 1'b0;
  logic [5:0] op_b;
  logic       pcw_b, iord_b, mrd_b, mwr_b, irw_b, rdst_b, m2r_b, rw_b, sa_b, ill_b;
  logic [1:0] sb_b, ps_b;
  logic [4:0] aop_b;
  logic [3:0] st_b;

  multicycle_control dut_a (
    .clk_i(clk), .reset_i(reset_a), .opcode_i(op_a), .zero_i(zero_a),
    .mem_ready_i(ready_a), .pc_write_o(pcw_a), .iord_o(iord_a),
    .mem_read_o(mrd_a), .mem_write_o(mwr_a), .ir_write_o(irw_a),
    .reg_dst_o(rdst_a), .mem_to_reg_o(m2r_a), .reg_write_o(rw_a),
    .alu_src_a_o(sa_a), .alu_src_b_o(sb_a), .pc_src_o(ps_a),
    .alu_op_o(aop_a), .state_o(st_a), .illegal_o(ill_a)
  );

  multicycle_control #(.ALU_OP_W(5), .USE_MEM_READY(0)) dut_b (
    .clk_i(clk), .reset_i(reset_b), .opcode_i(op_b), .zero_i(zero_b),
    .mem_ready_i(ready_b), .pc_write_o(pcw_b), .iord_o(iord_b),
    .mem_read_o(mrd_b), .mem_write_o(mwr_b), .ir_write_o(irw_b),
    .reg_dst_o(rdst_b), .mem_to_reg_o(m2r_b), .reg_write_o(rw_b),
    .alu_src_a_o(sa_b), .alu_src_b_o(sb_b), .pc_src_o(ps_b),
    .alu_op_o(aop_b), .state_o(st_b), .illegal_o(ill_b)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       ill, pcw, iord, mrd, mwr, irw, rdst, m2r, rw, sa;
    logic [1:0] sb, ps;
    logic [7:0] aop;
  } out_t;

  localparam logic [5:0] R = 6'h00, J = 6'h02, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D, LUI = 6'h0F;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2B;

  out_t q_a[$];
  out_t q_b[$];
  int   checks = 0;
  int   passed = 0;
  event sample_now;

  function automatic out_t act_a();
    out_t x;
    x = '{st: st_a, ill: ill_a, pcw: pcw_a, iord: iord_a, mrd: mrd_a, mwr: mwr_a,
          irw: irw_a, rdst: rdst_a, m2r: m2r_a, rw: rw_a, sa: sa_a, sb: sb_a,
          ps: ps_a, aop: {5'b0, aop_a}};
    return x;
  endfunction

  function automatic out_t act_b();
    out_t x;
    x = '{st: st_b, ill: ill_b, pcw: pcw_b, iord: iord_b, mrd: mrd_b, mwr: mwr_b,
          irw: irw_b, rdst: rdst_b, m2r: m2r_b, rw: rw_b, sa: sa_b, sb: sb_b,
          ps: ps_b, aop: {3'b0, aop_b}};
    return x;
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s exp_state=%0d actual=%h required=%h", nm, exp.st, act, exp);
  endtask

  // Monitor: every falling edge, or on request in mid-cycle.
  always begin
    out_t e;
    @(negedge clk or sample_now);
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("dut_a_outputs", act_a(), e);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("dut_b_outputs", act_b(), e);
    end
  end

  function automatic out_t blank(input int st);
    out_t e = '0;
    e.st = 4'(st);
    return e;
  endfunction

  function automatic out_t e_fetch(input logic go);
    out_t e = blank(0);
    e.mrd = 1'b1; e.sb = 2'b01; e.aop = 8'd4; e.pcw = go; e.irw = go;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  // Apply one cycle of inputs (called just after a rising edge) and queue
  // the outputs the instruction should show during that cycle.
  task automatic drive(input int d, input logic rst, input logic [5:0] op,
                       input logic rdy, input logic z, input out_t e);
    if (d == 0) begin
      reset_a = rst; op_a = op; ready_a = rdy; zero_a = z; q_a.push_back(e);
    end else begin
      reset_b = rst; op_b = op; zero_b = z; q_b.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // One complete instruction. fw/mw are memory wait cycles in FETCH and in
  // the data access; dut_b ignores mem_ready so it never waits.
  task automatic run_instr(input int d, input logic [5:0] op, input int fw,
                           input int mw, input logic z);
    out_t e;
    int   f = (d == 0) ? fw : 0;
    int   m = (d == 0) ? mw : 0;
    logic go = (d == 0);
    repeat (f) drive(d, 0, rop(), 1'b0, rbit(), e_fetch(1'b0));
    drive(d, 0, rop(), go, rbit(), e_fetch(1'b1));
    e = blank(1); e.sb = 2'b11; e.aop = 8'd4;
    drive(d, 0, op, rbit(), rbit(), e);
    case (op)
      LW, SW: begin
        e = blank(2); e.sa = 1; e.sb = 2'b10; e.aop = 8'd4;
        drive(d, 0, rop(), rbit(), rbit(), e);
        if (op == LW) begin
          e = blank(3); e.mrd = 1; e.iord = 1;
          repeat (m) drive(d, 0, rop(), 1'b0, rbit(), e);
          drive(d, 0, rop(), go, rbit(), e);
          e = blank(4); e.m2r = 1; e.rw = 1;
          drive(d, 0, rop(), rbit(), rbit(), e);
        end else begin
          e = blank(5); e.mwr = 1; e.iord = 1;
          repeat (m) drive(d, 0, rop(), 1'b0, rbit(), e);
          drive(d, 0, rop(), go, rbit(), e);
        end
      end
      R: begin
        e = blank(6); e.sa = 1; e.aop = 8'd7;
        drive(d, 0, rop(), rbit(), rbit(), e);
        e = blank(7); e.rdst = 1; e.rw = 1;
        drive(d, 0, rop(), rbit(), rbit(), e);
      end
      ADDI, ANDI, ORI, LUI: begin
        e = blank(8); e.sa = 1; e.sb = 2'b10;
        e.aop = (op == ADDI) ? 8'd4 : (op == ANDI) ? 8'd2 : (op == ORI) ? 8'd1 : 8'd0;
        drive(d, 0, rop(), rbit(), rbit(), e);
        e = blank(9); e.rw = 1;
        drive(d, 0, rop(), rbit(), rbit(), e);
      end
      BEQ, BNE: begin
        e = blank(10); e.sa = 1; e.aop = 8'd3; e.ps = 2'b01;
        e.pcw = (op == BEQ) ? z : !z;
        drive(d, 0, rop(), rbit(), z, e);
      end
      J: begin
        e = blank(11); e.ps = 2'b10; e.pcw = 1;
        drive(d, 0, rop(), rbit(), rbit(), e);
      end
      default: begin
        e = blank(15); e.ill = 1;
        repeat (10) drive(d, 0, rop(), rbit(), rbit(), e);
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal [10];
    out_t e;
    legal = '{R, J, BEQ, BNE, ADDI, ANDI, ORI, LUI, LW, SW};
    reset_a = 1; reset_b = 1; op_a = '0; op_b = '0; zero_a = 0; zero_b = 0; ready_a = 0;
    @(posedge clk); #1;

    // Reset state: everything low even with ready high.
    drive(0, 1, rop(), 1'b1, rbit(), blank(0));
    drive(0, 1, rop(), 1'b1, rbit(), blank(0));

    run_instr(0, R, 0, 0, 0);
    run_instr(0, LW, 0, 2, 0);
    run_instr(0, BEQ, 1, 0, 1);
    run_instr(0, BNE, 0, 0, 1);
    run_instr(0, BEQ, 0, 0, 0);
    run_instr(0, BNE, 0, 0, 0);
    run_instr(0, SW, 2, 1, 0);
    run_instr(0, J, 0, 0, 0);
    run_instr(0, ORI, 0, 0, 0);

    // Illegal opcode traps until reset.
    run_instr(0, 6'h3F, 0, 0, 0);
    drive(0, 1, rop(), rbit(), rbit(), blank(0));

    // Reset arriving mid-cycle while a store waits on memory.
    drive(0, 0, rop(), 1'b1, rbit(), e_fetch(1'b1));
    e = blank(1); e.sb = 2'b11; e.aop = 8'd4;
    drive(0, 0, SW, rbit(), rbit(), e);
    e = blank(2); e.sa = 1; e.sb = 2'b10; e.aop = 8'd4;
    drive(0, 0, rop(), rbit(), rbit(), e);
    e = blank(5); e.mwr = 1; e.iord = 1;
    drive(0, 0, rop(), 1'b0, rbit(), e);
    ready_a = 1'b0;
    reset_a = 1'b1;
    #1;
    q_a.push_back(blank(0));
    -> sample_now;
    #1;
    reset_a = 1'b0;
    q_a.push_back(e_fetch(1'b0));
    @(posedge clk); #1;
    run_instr(0, SW, 0, 0, 0);

    // Randomised instruction mix.
    for (int i = 0; i < 40; i++)
      run_instr(0, legal[$urandom_range(0, 9)], $urandom_range(0, 2),
                $urandom_range(0, 3), rbit());

    // dut_b: no memory handshake, 5-bit ALU op.
    reset_a = 1;
    drive(1, 1, rop(), 1'b0, rbit(), blank(0));
    run_instr(1, ORI, 0, 0, 0);
    run_instr(1, LW, 0, 0, 0);
    run_instr(1, SW, 0, 0, 0);
    run_instr(1, LUI, 0, 0, 0);
    run_instr(1, BEQ, 0, 0, 1);

    @(negedge clk); #1;
    checks++;
    if (q_a.size() == 0 && q_b.size() == 0) passed++;
    else $display("FAIL drain: pending a=%0d b=%0d required 0", q_a.size(), q_b.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
